// File: rtl/vc_frame_queue.sv
// vc_frame_queue
// Frame-aware first-word-fall-through virtual-channel queue. Bytes are
// written per frame; the reader only sees a frame once its eof byte has been
// committed. Aborted frames and frames that overflow are discarded whole.
//
// Ports:
//   clk_i        clock
//   rstn_i       asynchronous active-low reset
//   wr_en_i      write one byte this cycle
//   wr_data_i    byte to write
//   wr_eof_i     byte is the last of its frame (qualified by wr_en_i)
//   wr_abort_i   discard the uncommitted frame (any cycle)
//   rd_data_o    {eof, byte} at the read pointer, 0 when empty
//   empty_o      no committed entry available
//   read_i       pop the current entry (ignored when empty)
//   used_o       occupied entries, committed plus uncommitted
//   frame_cnt_o  committed frames not yet fully read
//   drop_o       one-cycle pulse when a frame is dropped for overflow
//
// Write FSM states:
//   state   | meaning
//   ACCEPT  | bytes are stored at wr_ptr; eof commits the frame
//   DISCARD | overflowed frame in progress; bytes ignored until eof or abort
module vc_frame_queue #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wr_en_i,
  input  logic [7:0]        wr_data_i,
  input  logic              wr_eof_i,
  input  logic              wr_abort_i,
  output logic [8:0]        rd_data_o,
  output logic              empty_o,
  input  logic              read_i,
  output logic [ADDR_W:0]   used_o,
  output logic [ADDR_W:0]   frame_cnt_o,
  output logic              drop_o
);

  localparam int PW = ADDR_W + 1;

  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } wr_state_e;

  wr_state_e     state_q, state_d;
  logic [8:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fcnt_q, fcnt_d;
  logic [PW-1:0] used;
  logic [8:0]    rd_q;
  logic [8:0]    wr_word;
  logic          full;
  logic          we;
  logic          commit;
  logic          drop_d, drop_q;
  logic          rd_fire;
  logic          rd_eof;

  assign wr_word = {wr_eof_i, wr_data_i};
  assign used    = wr_ptr_q - rd_ptr_q;
  assign full    = (used == PW'(DEPTH));
  assign empty_o = (rd_ptr_q == cmt_ptr_q);
  assign rd_fire = read_i & ~empty_o;
  assign rd_eof  = rd_fire & rd_q[8];
  assign rd_ptr_d = rd_ptr_q + (rd_fire ? PW'(1) : PW'(0));

  // Write FSM and pointer next-state
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    we        = 1'b0;
    commit    = 1'b0;
    drop_d    = 1'b0;
    if (wr_abort_i) begin
      wr_ptr_d = cmt_ptr_q;
      state_d  = ACCEPT;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (wr_en_i) begin
            if (!full) begin
              we       = 1'b1;
              wr_ptr_d = wr_ptr_q + PW'(1);
              if (wr_eof_i) begin
                cmt_ptr_d = wr_ptr_q + PW'(1);
                commit    = 1'b1;
              end
            end else begin
              wr_ptr_d = cmt_ptr_q;
              drop_d   = 1'b1;
              if (!wr_eof_i) state_d = DISCARD;
            end
          end
        end
        DISCARD: begin
          if (wr_en_i && wr_eof_i) state_d = ACCEPT;
        end
        default: state_d = ACCEPT;
      endcase
    end
  end

  always_comb begin
    fcnt_d = fcnt_q;
    case ({commit, rd_eof})
      2'b10:   fcnt_d = fcnt_q + PW'(1);
      2'b01:   fcnt_d = fcnt_q - PW'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ACCEPT;
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem[wr_ptr_q[ADDR_W-1:0]] <= wr_word;
  end

  // Lookahead read: fetch the entry at the pointer value of the next cycle.
  // A same-cycle write to that slot (queue empty, or the slot just behind the
  // last unread entry) is forwarded so a one-byte frame shows at N+1.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_q <= '0;
    end else if (we && (wr_ptr_q[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0])) begin
      rd_q <= wr_word;
    end else begin
      rd_q <= mem[rd_ptr_d[ADDR_W-1:0]];
    end
  end

  assign rd_data_o   = empty_o ? 9'h000 : rd_q;
  assign used_o      = used;
  assign frame_cnt_o = fcnt_q;
  assign drop_o      = drop_q;

endmodule
